// File: rtl/soc_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pio_pkg
// Description : Shared constants for the DMA address-queue PIO: register
//               offsets within a channel window, status bit positions and
//               control bit positions.
// Revision    : 1.0 - initial multi-channel address-queue release
// ============================================================================
package soc_pio_pkg;

    // Register offsets (address[1:0]) inside each channel's window
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;

    // Status register bit positions (count sits in the low bits)
    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;

    // Control register bit positions (self-clearing strobes)
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/soc_pio_adr_fifo_ch.sv
`default_nettype none
// ============================================================================
// Module      : soc_pio_adr_fifo_ch
// Description : Single-channel address FIFO with push/pop/flush and a sticky
//               overflow flag. Storage is not reset; pointers, count and the
//               overflow flag are.
// Ports       : clk, reset_n     - clock, async active-low reset
//               i_push/i_push_data - enqueue request and its data
//               i_pop              - consumer accept (ignored when empty)
//               i_flush            - empty the FIFO (wins over push/pop)
//               i_clr_ovf          - clear the sticky overflow flag
//               o_data             - head entry (0 while empty)
//               o_count/o_empty/o_full/o_overflow - status
// Revision    : 1.0 - initial release
// ============================================================================
module soc_pio_adr_fifo_ch #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic              i_clr_ovf,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q, overflow_d;

    logic empty, full, do_pop, do_push, push_ovf;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = i_pop & ~empty & ~i_flush;
        // A full FIFO still accepts a push when an entry leaves in the same cycle
        do_push  = i_push & (~full | do_pop) & ~i_flush;
        // A push swallowed by flush is not an overflow
        push_ovf = i_push & full & ~do_pop & ~i_flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Set beats clear when both happen together
        overflow_d = overflow_q;
        if (i_clr_ovf) overflow_d = 1'b0;
        if (push_ovf)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

    // Gate with empty so uninitialised storage never reaches the consumer
    assign o_data     = empty ? '0 : mem_q[rd_ptr_q];
    assign o_count    = count_q;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_overflow = overflow_q;

endmodule
`default_nettype wire

// File: rtl/soc_pio_dma_adr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : soc_pio_dma_adr_fifo
// Description : Multi-channel Avalon-MM address-queue peripheral. The CPU
//               pushes DMA addresses per channel; each DMA engine pops its
//               channel through valid/ready. Zero-wait-state slave.
// Ports       : clk, reset_n            - clock, async active-low reset
//               address                 - [1:0] register offset, upper = channel
//               chipselect, write_n     - Avalon slave strobes
//               writedata / readdata    - Avalon data (readdata combinational)
//               out_data/out_valid/out_ready - per-channel head and handshake
// Revision    : 1.0 - initial release
// ============================================================================
module soc_pio_dma_adr_fifo
    import soc_pio_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 4,
    localparam int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // One spare bit so CHANNELS=1 still has a non-empty channel field
    localparam int IDX_W = ADDR_W - 1;

    logic             wr;
    logic [1:0]       offset;
    logic [IDX_W-1:0] ch_idx;

    logic [DATA_W-1:0] ch_data     [CHANNELS];
    logic [CNT_W-1:0]  ch_count    [CHANNELS];
    logic              ch_empty    [CHANNELS];
    logic              ch_full     [CHANNELS];
    logic              ch_overflow [CHANNELS];

    assign wr     = chipselect & ~write_n;
    assign offset = address[1:0];
    assign ch_idx = IDX_W'({1'b0, address} >> 2);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic sel;
        assign sel = wr & (ch_idx == IDX_W'(c));

        soc_pio_adr_fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_push      (sel & (offset == OFS_DATA)),
            .i_push_data (writedata[DATA_W-1:0]),
            .i_pop       (out_ready[c]),
            .i_flush     (sel & (offset == OFS_CTRL) & writedata[CTRL_FLUSH_BIT]),
            .i_clr_ovf   (sel & (offset == OFS_CTRL) & writedata[CTRL_CLR_OVF_BIT]),
            .o_data      (ch_data[c]),
            .o_count     (ch_count[c]),
            .o_empty     (ch_empty[c]),
            .o_full      (ch_full[c]),
            .o_overflow  (ch_overflow[c])
        );

        assign out_data[c*DATA_W +: DATA_W] = ch_data[c];
        assign out_valid[c]                 = ~ch_empty[c];
    end

    // Unmatched channel indices and the control/reserved offsets read 0
    always_comb begin
        readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == IDX_W'(c)) begin
                case (offset)
                    OFS_DATA:   readdata = 32'(ch_data[c]);
                    OFS_STATUS: begin
                        readdata[CNT_W-1:0]     = ch_count[c];
                        readdata[STAT_EMPTY_BIT] = ch_empty[c];
                        readdata[STAT_FULL_BIT]  = ch_full[c];
                        readdata[STAT_OVF_BIT]   = ch_overflow[c];
                    end
                    default:    readdata = '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_pio_dma_adr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_pio_dma_adr_fifo
// Description : Self-checking bench for soc_pio_dma_adr_fifo: directed
//               scenarios followed by random Avalon/consumer traffic, all
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_pio_dma_adr_fifo;

    localparam int DATA_W   = 32;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = $clog2(CHANNELS) + 2;

    logic                       clk        = 1'b0;
    logic                       reset_n    = 1'b0;
    logic [ADDR_W-1:0]          address    = '0;
    logic                       chipselect = 1'b0;
    logic                       write_n    = 1'b1;
    logic [31:0]                writedata  = '0;
    logic [31:0]                readdata;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic [CHANNELS-1:0]        out_valid;
    logic [CHANNELS-1:0]        out_ready  = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus the sticky overflow flag
    logic [DATA_W-1:0] mq   [CHANNELS][$];
    bit                movf [CHANNELS];

    soc_pio_dma_adr_fifo #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #10 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(int ch, int ofs);
        logic [31:0] r;
        int          n;
        r = '0;
        if (ch < CHANNELS) begin
            n = mq[ch].size();
            if (ofs == 0 && n > 0) r = 32'(mq[ch][0]);
            if (ofs == 1) begin
                r     = 32'(n);
                r[16] = (n == 0);
                r[17] = (n == DEPTH);
                r[18] = movf[ch];
            end
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] adr(int ch, int ofs);
        return ADDR_W'((ch << 2) | ofs);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            mq[c].delete();
            movf[c] = 1'b0;
        end
    endtask

    // Advance one clock edge and apply the same edge to the model
    task automatic step();
        bit wr, sel, push, flush, clr, pop, room;
        int ch, ofs;
        @(posedge clk);
        wr  = chipselect & ~write_n;
        ch  = int'(address >> 2);
        ofs = int'(address[1:0]);
        for (int c = 0; c < CHANNELS; c++) begin
            sel   = wr && (ch == c);
            push  = sel && (ofs == 0);
            flush = sel && (ofs == 2) && writedata[0];
            clr   = sel && (ofs == 2) && writedata[1];
            pop   = out_ready[c] && (mq[c].size() > 0);
            room  = mq[c].size() < DEPTH;
            if (clr) movf[c] = 1'b0;
            if (flush) begin
                mq[c].delete();
            end else begin
                if (pop) void'(mq[c].pop_front());
                if (push) begin
                    if (room || pop) mq[c].push_back(writedata[DATA_W-1:0]);
                    else             movf[c] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic av_wr(int ch, int ofs, logic [31:0] d);
        address    = adr(ch, ofs);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(int ch, int ofs, output logic [31:0] v);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = adr(ch, ofs);
        #1;
        v = readdata;
    endtask

    // Compare every readable register and both stream ports against the model
    task automatic check_all(string tag);
        logic [31:0] v;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int o = 0; o < 4; o++) begin
                rd(c, o, v);
                chk($sformatf("%s rd ch%0d ofs%0d", tag, c, o), v, exp_rd(c, o));
            end
            chk($sformatf("%s valid ch%0d", tag, c), 32'(out_valid[c]),
                32'(mq[c].size() != 0));
            if (mq[c].size() != 0)
                chk($sformatf("%s out_data ch%0d", tag, c),
                    32'(out_data[c*DATA_W +: DATA_W]), 32'(mq[c][0]));
        end
    endtask

    initial begin
        logic [31:0] v;
        int          r, c;

        model_reset();
        #25 reset_n = 1'b1;
        step();

        // Reset state
        rd(0, 1, v);
        chk("reset status ch0", v, 32'h0001_0000);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", out_data[31:0], 32'h0);
        check_all("reset");

        // Two pushes to ch0 then drain
        av_wr(0, 0, 32'h1000);
        check_all("push1");
        av_wr(0, 0, 32'h2000);
        check_all("push2");
        chk("ch0 head", out_data[31:0], 32'h1000);
        out_ready[0] = 1'b1;
        step();
        check_all("pop1");
        chk("ch0 head after pop", out_data[31:0], 32'h2000);
        rd(0, 1, v);
        chk("ch0 status count1", v, 32'h0000_0001);
        step();
        out_ready[0] = 1'b0;
        rd(0, 1, v);
        chk("ch0 status empty", v, 32'h0001_0000);
        check_all("pop2");

        // Overflow on ch1
        for (int i = 0; i < 5; i++) av_wr(1, 0, 32'hA0 + 32'(i));
        rd(1, 1, v);
        chk("ch1 overflow status", v, 32'h0006_0004);
        check_all("ovf");
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ch1 pop %0d", i), out_data[63:32], 32'hA0 + 32'(i));
            step();
            check_all("ovf drain");
        end
        out_ready[1] = 1'b0;
        av_wr(1, 2, 32'h2);
        rd(1, 1, v);
        chk("ch1 ovf cleared", v, 32'h0001_0000);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) av_wr(0, 0, $urandom);
        out_ready[0] = 1'b1;
        av_wr(0, 0, 32'hBEEF);
        out_ready[0] = 1'b0;
        rd(0, 1, v);
        chk("full push+pop status", v, 32'h0002_0004);
        check_all("full pushpop");
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("drain beef");
        end
        chk("beef last", out_data[31:0], 32'hBEEF);
        step();
        out_ready[0] = 1'b0;
        check_all("drained");

        // Flush wins over a same-cycle pop
        for (int i = 0; i < 3; i++) av_wr(1, 0, $urandom);
        out_ready[1] = 1'b1;
        av_wr(1, 2, 32'h1);
        out_ready[1] = 1'b0;
        chk("flush valid ch1", 32'(out_valid[1]), 32'h0);
        rd(1, 1, v);
        chk("flush status ch1", v, 32'h0001_0000);
        check_all("flush");

        // Asynchronous reset mid-stream
        av_wr(0, 0, 32'h55);
        av_wr(1, 0, 32'h55);
        chk("pre-reset valid", 32'(out_valid), 32'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset valid", 32'(out_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        rd(0, 1, v);
        chk("post-reset status ch0", v, 32'h0001_0000);
        rd(1, 1, v);
        chk("post-reset status ch1", v, 32'h0001_0000);
        check_all("post reset");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            out_ready = CHANNELS'($urandom);
            r = $urandom_range(0, 9);
            c = $urandom_range(0, CHANNELS - 1);
            if (r < 5) begin
                av_wr(c, 0, $urandom);
            end else if (r == 5) begin
                av_wr(c, 2, ($urandom_range(0, 3) == 0) ? 32'h3 : 32'h2);
            end else if (r == 6) begin
                av_wr(c, ($urandom_range(0, 1) == 0) ? 1 : 3, $urandom);
            end else begin
                step();
            end
            check_all("random");
        end
        out_ready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
